// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Fetch-unit bus bundle: instruction-memory request/response,
//               PC redirect, and the decode-side valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        id_ready;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner and in-order instruction queue feeding decode, with
//               credit-based request issue and redirect flush of wrong-path
//               queued and in-flight instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);

    localparam int             c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0] c_DEPTH = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]        r_q_instr [FIFO_DEPTH];
    logic [31:0]        r_q_pc    [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [CNT_W-1:0]   r_q_count;
    logic [CNT_W-1:0]   r_live_cnt;
    logic [CNT_W-1:0]   r_stale_cnt;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_rsp_pc;

    logic [CNT_W:0]     w_credit_used;
    logic [CNT_W:0]     w_outstanding;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_rsp_taken;
    logic               w_rsp_drop;
    logic               w_rsp_push;
    logic               w_if_valid;
    logic               w_pop;
    logic [31:0]        w_redirect_tgt;
    logic               w_unused_redirect_bits;

    // Credits cover queued plus in-flight current-path words, so a response
    // always finds a free slot even when the queue is full and popping.
    assign w_credit_used = {1'b0, r_q_count} + {1'b0, r_live_cnt};
    assign w_outstanding = {1'b0, r_live_cnt} + {1'b0, r_stale_cnt};
    assign w_req_valid   = !reset && !bus.redirect_valid && (w_credit_used < c_DEPTH);
    assign w_req_fire    = w_req_valid && bus.imem_req_ready;
    assign w_rsp_taken   = bus.imem_rsp_valid && (w_outstanding != '0);
    assign w_rsp_drop    = bus.imem_rsp_valid && (r_stale_cnt != '0);
    assign w_rsp_push    = bus.imem_rsp_valid && (r_stale_cnt == '0) && (r_live_cnt != '0)
                           && !bus.redirect_valid;
    assign w_if_valid    = (r_q_count != '0);
    assign w_pop         = w_if_valid && bus.id_ready;

    assign w_redirect_tgt         = {bus.redirect_pc[31:2], 2'b00};
    assign w_unused_redirect_bits = ^bus.redirect_pc[1:0];

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_fetch_pc;
    assign bus.if_valid       = w_if_valid;
    assign bus.if_instr       = w_if_valid ? r_q_instr[r_head] : 32'h0;
    assign bus.if_pc          = w_if_valid ? r_q_pc[r_head] : 32'h0;
    assign bus.if_pc_plus4    = w_if_valid ? (r_q_pc[r_head] + 32'd4) : 32'h0;

    always_ff @(posedge clk) begin
        if (w_rsp_push) begin
            r_q_instr[r_tail] <= bus.imem_rsp_data;
            r_q_pc[r_tail]    <= r_rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc  <= RESET_PC;
            r_rsp_pc    <= RESET_PC;
            r_head      <= '0;
            r_tail      <= '0;
            r_q_count   <= '0;
            r_live_cnt  <= '0;
            r_stale_cnt <= '0;
        end else if (bus.redirect_valid) begin
            // Everything still in flight becomes stale; a response landing
            // this cycle is already consumed and not counted again.
            r_fetch_pc  <= w_redirect_tgt;
            r_rsp_pc    <= w_redirect_tgt;
            r_head      <= '0;
            r_tail      <= '0;
            r_q_count   <= '0;
            r_live_cnt  <= '0;
            r_stale_cnt <= CNT_W'(w_outstanding - {{CNT_W{1'b0}}, w_rsp_taken});
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_rsp_drop) begin
                r_stale_cnt <= r_stale_cnt - CNT_W'(1);
            end
            if (w_rsp_push) begin
                r_tail   <= r_tail + c_PTR_W'(1);
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            r_live_cnt <= r_live_cnt + CNT_W'(w_req_fire) - CNT_W'(w_rsp_push);
            r_q_count  <= r_q_count + CNT_W'(w_rsp_push) - CNT_W'(w_pop);
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        bus.imem_rsp_valid |-> (w_outstanding != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        w_rsp_push |-> (({1'b0, r_q_count} < c_DEPTH) || w_pop));

endmodule
`default_nettype wire
